// File: rtl/moore_seq_pkg.sv
// Shared types and constants for the Moore-detector sequencer.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package moore_seq_pkg;

  // Run phases of the sequencer; encoding is internal only.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_PRE_W  = 4;
  localparam int DEF_CNT_W  = 4;

  // Largest value a w-bit unsigned counter can hold.
  function automatic logic [31:0] cnt_max(input int unsigned w);
    cnt_max = (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/moore_seq_prescaler.sv
// Loadable down-counter that ticks at zero and reloads itself on the tick.
// Latency: tick is combinational from the count; load/step take effect next cycle.
// Backpressure: step=0 holds the count (used for enable/abort freezing).
//
// Ports:
//   clk, rst_n   clock, async active-low reset
//   load         force the count to load_val (wins over step)
//   load_val     value loaded by load
//   step         advance: decrement, or reload from reload_val when at zero
//   reload_val   value reloaded after each tick
//   tick         count is zero
module moore_seq_prescaler #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         step,
  input  logic [W-1:0] reload_val,
  output logic         tick
);

  logic [W-1:0] cnt_q;

  assign tick = (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (step) begin
      cnt_q <= tick ? reload_val : cnt_q - W'(1);
    end
  end

endmodule

// File: rtl/moore_seq_driver.sv
// Feeds a captured pattern MSB-first to a Moore detector and counts its hits.
// Latency: first strobe 1 cycle after start, then every div+1 cycles; done 2 cycles after last strobe.
// Backpressure: ena=0 freezes everything (strobes/samples wait); abort cancels a run.
//
// Ports:
//   clk, rst_n  clock, async active-low reset (release expected synchronous to clk)
//   ena         global enable; low freezes all state, forces bit_valid/done to 0
//   start       launch request, honoured only in IDLE
//   abort       cancel a run in SHIFT/DRAIN, no done pulse
//   data_in     pattern captured at start
//   div         rate divider captured at start (strobe period div+1)
//   det_in      detector Moore output, sampled the cycle after each strobe
//   bit_out     serial bit, holds between strobes
//   bit_valid   one-cycle strobe per bit
//   busy        SHIFT or DRAIN
//   done        one-cycle pulse on normal completion
//   hit_count   saturating count of samples with det_in=1
//   hit_ovf     sticky, set when an increment is attempted at the maximum
module moore_seq_driver
  import moore_seq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int PRE_W  = DEF_PRE_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] data_in,
  input  logic [PRE_W-1:0]  div,
  input  logic              det_in,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  hit_count,
  output logic              hit_ovf
);

  localparam int                IDX_W    = $clog2(DATA_W);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]  HIT_MAX  = CNT_W'(cnt_max(CNT_W));

  seq_state_t          state_q, state_d;
  logic [DATA_W-1:0]   shreg_q;
  logic [PRE_W-1:0]    div_q;
  logic [IDX_W-1:0]    idx_q;
  logic                bit_out_q;
  logic                sample_pend_q;
  logic [CNT_W-1:0]    hit_count_q;
  logic                hit_ovf_q;

  logic accept;
  logic kill;
  logic tick;
  logic strobe;
  logic take;
  logic last_bit;

  assign accept   = ena && (state_q == ST_IDLE) && start;
  // abort only acts on a run in progress, and beats any strobe/sample that cycle
  assign kill     = ena && abort && ((state_q == ST_SHIFT) || (state_q == ST_DRAIN));
  assign strobe   = ena && (state_q == ST_SHIFT) && !abort && tick;
  assign take     = ena && sample_pend_q && !kill;
  assign last_bit = (idx_q == '0);

  moore_seq_prescaler #(
    .W(PRE_W)
  ) u_prescaler (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (accept),
    .load_val   ({PRE_W{1'b0}}),
    .step       (ena && (state_q == ST_SHIFT) && !abort),
    .reload_val (div_q),
    .tick       (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (ena) begin
      case (state_q)
        ST_IDLE:  if (accept) state_d = ST_SHIFT;
        ST_SHIFT: begin
          if (kill)                    state_d = ST_IDLE;
          else if (strobe && last_bit) state_d = ST_DRAIN;
        end
        ST_DRAIN: state_d = kill ? ST_IDLE : ST_DONE;
        ST_DONE:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q       <= '0;
      div_q         <= '0;
      idx_q         <= '0;
      bit_out_q     <= 1'b0;
      sample_pend_q <= 1'b0;
      hit_count_q   <= '0;
      hit_ovf_q     <= 1'b0;
    end else if (accept) begin
      shreg_q       <= data_in;
      div_q         <= div;
      idx_q         <= IDX_LAST;
      sample_pend_q <= 1'b0;
      hit_count_q   <= '0;
      hit_ovf_q     <= 1'b0;
    end else begin
      if (strobe) begin
        shreg_q   <= shreg_q << 1;
        bit_out_q <= shreg_q[DATA_W-1];
        if (!last_bit) idx_q <= idx_q - IDX_W'(1);
      end

      // A strobe in the same cycle as a sample re-arms the flag for the next bit.
      if (kill)        sample_pend_q <= 1'b0;
      else if (strobe) sample_pend_q <= 1'b1;
      else if (take)   sample_pend_q <= 1'b0;

      if (take && det_in) begin
        if (hit_count_q == HIT_MAX) hit_ovf_q   <= 1'b1;
        else                        hit_count_q <= hit_count_q + CNT_W'(1);
      end
    end
  end

  // During a strobe the new bit is presented immediately; otherwise the last one holds.
  assign bit_out   = strobe ? shreg_q[DATA_W-1] : bit_out_q;
  assign bit_valid = strobe;
  assign busy      = (state_q == ST_SHIFT) || (state_q == ST_DRAIN);
  assign done      = ena && (state_q == ST_DONE);
  assign hit_count = hit_count_q;
  assign hit_ovf   = hit_ovf_q;

endmodule
